// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared parity-mode constants, FSM state types and parity
//               helper for the UART port.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam logic [1:0] c_PAR_NONE = 2'd0;
    localparam logic [1:0] c_PAR_ODD  = 2'd1;
    localparam logic [1:0] c_PAR_EVEN = 2'd2;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_t;

    // Payload is zero-extended to 8 bits, so padding never changes the result.
    function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] mode);
        return (mode == c_PAR_ODD) ? ~(^data) : (^data);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : First-word-fall-through receive FIFO; a push into a full
//               FIFO succeeds when a pop happens in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;
    logic             w_wr_en;
    logic             w_rd_en;

    assign level   = r_wr_ptr - r_rd_ptr;
    assign empty   = (level == '0);
    assign full    = (level == (c_AW + 1)'(DEPTH));
    assign w_rd_en = pop && !empty;
    assign w_wr_en = push && (!full || w_rd_en);
    assign head    = r_mem[r_rd_ptr[c_AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: empty hides its contents.
    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_ptr[c_AW-1:0]] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/uart_port.sv
`default_nettype none
// ============================================================================
// Module      : uart_port
// Description : UART transmitter/receiver with cts/rts flow control and a
//               receive FIFO carrying per-frame parity/framing flags.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_port
    import uart_pkg::*;
#(
    parameter int BIT_CLK   = 87,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int RX_DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 txd,
    input  logic                 cts,
    input  logic                 rxd,
    output logic                 rts,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_perr,
    output logic                 rx_ferr,
    output logic                 rx_overrun
);
    localparam int                 c_CNT_W     = $clog2(STOP_BITS * BIT_CLK + 1);
    localparam int                 c_FIFO_W    = DATA_BITS + 2;
    localparam int                 c_LVL_W     = $clog2(RX_DEPTH) + 1;
    localparam logic [c_CNT_W-1:0] c_BIT_LAST  = c_CNT_W'(BIT_CLK - 1);
    localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(BIT_CLK / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_STOP_LAST = c_CNT_W'(STOP_BITS * BIT_CLK - 1);
    localparam logic [2:0]         c_DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [1:0]         c_PAR_MODE  = 2'(PARITY);
    localparam logic [c_LVL_W-1:0] c_RTS_MAX   = c_LVL_W'(RX_DEPTH - 2);

    // ------------------------------------------------------------------
    // Input synchronizers (idle-high so reset looks like an idle line)
    // ------------------------------------------------------------------
    logic r_cts_s1, r_cts_s2, r_rxd_s1, r_rxd_s2, r_rxd_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cts_s1 <= 1'b1;
            r_cts_s2 <= 1'b1;
            r_rxd_s1 <= 1'b1;
            r_rxd_s2 <= 1'b1;
            r_rxd_d  <= 1'b1;
        end else begin
            r_cts_s1 <= cts;
            r_cts_s2 <= r_cts_s1;
            r_rxd_s1 <= rxd;
            r_rxd_s2 <= r_rxd_s1;
            r_rxd_d  <= r_rxd_s2;
        end
    end

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    tx_state_t            r_tx_state, w_tx_state_nxt;
    logic [c_CNT_W-1:0]   r_tx_cnt, w_tx_cnt_nxt;
    logic [2:0]           r_tx_bit, w_tx_bit_nxt;
    logic [DATA_BITS-1:0] r_tx_shift, w_tx_shift_nxt;
    logic                 r_tx_par, w_tx_par_nxt;
    logic                 r_tx_ready;
    logic                 w_tx_accept;
    logic                 w_txd;

    assign w_tx_accept = tx_valid && r_tx_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
            r_tx_ready <= 1'b0;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_tx_cnt   <= w_tx_cnt_nxt;
            r_tx_bit   <= w_tx_bit_nxt;
            r_tx_shift <= w_tx_shift_nxt;
            r_tx_par   <= w_tx_par_nxt;
            // cts is only honoured here, so a frame in flight always completes
            r_tx_ready <= (w_tx_state_nxt == TX_IDLE) && r_cts_s2;
        end
    end

    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_cnt_nxt   = r_tx_cnt + 1'b1;
        w_tx_bit_nxt   = r_tx_bit;
        w_tx_shift_nxt = r_tx_shift;
        w_tx_par_nxt   = r_tx_par;
        w_txd          = 1'b1;
        case (r_tx_state)
            TX_IDLE: begin
                w_tx_cnt_nxt = '0;
                if (w_tx_accept) begin
                    w_tx_shift_nxt = tx_data;
                    w_tx_par_nxt   = parity_bit(8'(tx_data), c_PAR_MODE);
                    w_tx_bit_nxt   = '0;
                    w_tx_state_nxt = TX_START;
                end
            end
            TX_START: begin
                w_txd = 1'b0;
                if (r_tx_cnt == c_BIT_LAST) begin
                    w_tx_cnt_nxt   = '0;
                    w_tx_state_nxt = TX_DATA;
                end
            end
            TX_DATA: begin
                w_txd = r_tx_shift[0];
                if (r_tx_cnt == c_BIT_LAST) begin
                    w_tx_cnt_nxt   = '0;
                    w_tx_shift_nxt = r_tx_shift >> 1;
                    w_tx_bit_nxt   = r_tx_bit + 1'b1;
                    if (r_tx_bit == c_DATA_LAST)
                        w_tx_state_nxt = (c_PAR_MODE == c_PAR_NONE) ? TX_STOP : TX_PARITY;
                end
            end
            TX_PARITY: begin
                w_txd = r_tx_par;
                if (r_tx_cnt == c_BIT_LAST) begin
                    w_tx_cnt_nxt   = '0;
                    w_tx_state_nxt = TX_STOP;
                end
            end
            TX_STOP: begin
                if (r_tx_cnt == c_STOP_LAST) begin
                    w_tx_cnt_nxt   = '0;
                    w_tx_state_nxt = TX_IDLE;
                end
            end
            default: begin
                w_tx_cnt_nxt   = '0;
                w_tx_state_nxt = TX_IDLE;
            end
        endcase
    end

    assign tx_ready = r_tx_ready;
    assign txd      = w_txd;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    rx_state_t            r_rx_state, w_rx_state_nxt;
    logic [c_CNT_W-1:0]   r_rx_cnt, w_rx_cnt_nxt;
    logic [2:0]           r_rx_bit, w_rx_bit_nxt;
    logic [DATA_BITS-1:0] r_rx_shift, w_rx_shift_nxt;
    logic                 r_rx_perr, w_rx_perr_nxt;
    logic                 w_rx_push;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_perr  <= 1'b0;
        end else begin
            r_rx_state <= w_rx_state_nxt;
            r_rx_cnt   <= w_rx_cnt_nxt;
            r_rx_bit   <= w_rx_bit_nxt;
            r_rx_shift <= w_rx_shift_nxt;
            r_rx_perr  <= w_rx_perr_nxt;
        end
    end

    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rx_cnt_nxt   = r_rx_cnt + 1'b1;
        w_rx_bit_nxt   = r_rx_bit;
        w_rx_shift_nxt = r_rx_shift;
        w_rx_perr_nxt  = r_rx_perr;
        w_rx_push      = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                w_rx_cnt_nxt  = '0;
                w_rx_perr_nxt = 1'b0;
                if (r_rxd_d && !r_rxd_s2) w_rx_state_nxt = RX_START;
            end
            RX_START: begin
                // Half-bit recheck filters glitches and aligns later samples to bit centres
                if (r_rx_cnt == c_HALF_LAST) begin
                    w_rx_cnt_nxt   = '0;
                    w_rx_bit_nxt   = '0;
                    w_rx_state_nxt = r_rxd_s2 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (r_rx_cnt == c_BIT_LAST) begin
                    w_rx_cnt_nxt   = '0;
                    w_rx_shift_nxt = {r_rxd_s2, r_rx_shift[DATA_BITS-1:1]};
                    w_rx_bit_nxt   = r_rx_bit + 1'b1;
                    if (r_rx_bit == c_DATA_LAST)
                        w_rx_state_nxt = (c_PAR_MODE == c_PAR_NONE) ? RX_STOP : RX_PARITY;
                end
            end
            RX_PARITY: begin
                if (r_rx_cnt == c_BIT_LAST) begin
                    w_rx_cnt_nxt   = '0;
                    w_rx_perr_nxt  = (r_rxd_s2 != parity_bit(8'(r_rx_shift), c_PAR_MODE));
                    w_rx_state_nxt = RX_STOP;
                end
            end
            RX_STOP: begin
                if (r_rx_cnt == c_BIT_LAST) begin
                    w_rx_cnt_nxt   = '0;
                    w_rx_push      = 1'b1;
                    w_rx_state_nxt = RX_IDLE;
                end
            end
            default: begin
                w_rx_cnt_nxt   = '0;
                w_rx_state_nxt = RX_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Receive FIFO and flow control
    // ------------------------------------------------------------------
    logic [c_FIFO_W-1:0] w_fifo_head;
    logic                w_fifo_empty;
    logic                w_fifo_full;
    logic [c_LVL_W-1:0]  w_fifo_level;
    logic                w_pop;
    logic                r_rts;
    logic                r_overrun;

    assign w_pop = !w_fifo_empty && rx_ready;

    uart_rx_fifo #(
        .WIDTH (c_FIFO_W),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_rx_push),
        .push_data ({r_rx_shift, r_rx_perr, !r_rxd_s2}),
        .pop       (w_pop),
        .head      (w_fifo_head),
        .empty     (w_fifo_empty),
        .full      (w_fifo_full),
        .level     (w_fifo_level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rts     <= 1'b1;
            r_overrun <= 1'b0;
        end else begin
            r_rts     <= (w_fifo_level <= c_RTS_MAX);
            r_overrun <= w_rx_push && w_fifo_full && !w_pop;
        end
    end

    assign rts        = r_rts;
    assign rx_overrun = r_overrun;
    assign rx_valid   = !w_fifo_empty;
    assign rx_data    = w_fifo_head[c_FIFO_W-1:2];
    assign rx_perr    = rx_valid && w_fifo_head[1];
    assign rx_ferr    = rx_valid && w_fifo_head[0];

endmodule
`default_nettype wire

// File: tb/tb_uart_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_port
// Description : Self-checking bench: 8N1 port (TX waveform, flow control,
//               overrun, reset), 7E2 loopback port and 8O1 receive port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_port;
    localparam int BIT = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // Port A: 8N1, depth 4
    logic [7:0] tx_data_a, rx_data_a;
    logic tx_valid_a, tx_ready_a, txd_a, cts_a, rxd_a, rts_a;
    logic rx_valid_a, rx_ready_a, rx_perr_a, rx_ferr_a, rx_overrun_a;
    // Port B: 7E2, txd looped back to rxd
    logic [6:0] tx_data_b, rx_data_b;
    logic tx_valid_b, tx_ready_b, txd_b, cts_b, rxd_b, rts_b;
    logic rx_valid_b, rx_ready_b, rx_perr_b, rx_ferr_b, rx_overrun_b;
    // Port C: 8O1, rxd driven by the bench
    logic [7:0] tx_data_c, rx_data_c;
    logic tx_valid_c, tx_ready_c, txd_c, cts_c, rxd_c, rts_c;
    logic rx_valid_c, rx_ready_c, rx_perr_c, rx_ferr_c, rx_overrun_c;

    assign rxd_b = txd_b;

    uart_port #(.BIT_CLK(BIT), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .RX_DEPTH(4)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
        .txd(txd_a), .cts(cts_a), .rxd(rxd_a), .rts(rts_a), .rx_data(rx_data_a), .rx_valid(rx_valid_a),
        .rx_ready(rx_ready_a), .rx_perr(rx_perr_a), .rx_ferr(rx_ferr_a), .rx_overrun(rx_overrun_a));

    uart_port #(.BIT_CLK(BIT), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .RX_DEPTH(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
        .txd(txd_b), .cts(cts_b), .rxd(rxd_b), .rts(rts_b), .rx_data(rx_data_b), .rx_valid(rx_valid_b),
        .rx_ready(rx_ready_b), .rx_perr(rx_perr_b), .rx_ferr(rx_ferr_b), .rx_overrun(rx_overrun_b));

    uart_port #(.BIT_CLK(BIT), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .RX_DEPTH(4)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data_c), .tx_valid(tx_valid_c), .tx_ready(tx_ready_c),
        .txd(txd_c), .cts(cts_c), .rxd(rxd_c), .rts(rts_c), .rx_data(rx_data_c), .rx_valid(rx_valid_c),
        .rx_ready(rx_ready_c), .rx_perr(rx_perr_c), .rx_ferr(rx_ferr_c), .rx_overrun(rx_overrun_c));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Overrun pulses seen on port A
    int ovr_cnt = 0;
    always @(negedge clk) if (rx_overrun_a === 1'b1) ovr_cnt++;

    // Reference frame: start, data LSB first, optional parity, stop bits
    logic bitq[$];
    task automatic build_frame(input logic [7:0] d, input int nbits, input int par,
                               input logic flip, input logic stop_val, input int nstop);
        int ones;
        ones = 0;
        bitq.delete();
        bitq.push_back(1'b0);
        for (int i = 0; i < nbits; i++) begin
            bitq.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (par == 1) bitq.push_back(((ones % 2) == 0) ^ flip);
        if (par == 2) bitq.push_back(((ones % 2) == 1) ^ flip);
        for (int i = 0; i < nstop; i++) bitq.push_back(stop_val);
    endtask

    task automatic set_rxd(input int sel, input logic v);
        if (sel == 0) rxd_a = v;
        else rxd_c = v;
    endtask

    task automatic drive_rx(input int sel, input logic [7:0] d, input int par,
                            input logic flip, input logic stop_val);
        build_frame(d, 8, par, flip, stop_val, 1);
        foreach (bitq[i]) begin
            set_rxd(sel, bitq[i]);
            repeat (BIT) @(negedge clk);
        end
        set_rxd(sel, 1'b1);
        repeat (2 * BIT) @(negedge clk);
    endtask

    task automatic tx_frame_a(input logic [7:0] d, input bit drop_cts);
        int waited, errs, low_cnt, total;
        build_frame(d, 8, 0, 1'b0, 1'b1, 1);
        total = bitq.size() * BIT;
        waited = 0;
        while (tx_ready_a !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        chk("a_tx_ready_wait", tx_ready_a, 1);
        tx_data_a  = d;
        tx_valid_a = 1'b1;
        @(negedge clk);
        tx_valid_a = 1'b0;
        errs = 0;
        low_cnt = 0;
        for (int i = 0; i < total; i++) begin
            if (drop_cts && i == 20) cts_a = 1'b0;
            if (drop_cts && i == 60) cts_a = 1'b1;
            if (txd_a !== bitq[i / BIT]) errs++;
            if (tx_ready_a === 1'b0) low_cnt++;
            @(negedge clk);
        end
        chk("a_txd_waveform_errors", errs, 0);
        chk("a_tx_ready_low_cycles", low_cnt, total);
        chk("a_tx_ready_after_frame", tx_ready_a, 1);
        chk("a_txd_idle_after_frame", txd_a, 1);
    endtask

    task automatic loop_b(input logic [6:0] d);
        int waited, frame_len;
        bit got;
        waited = 0;
        while (tx_ready_b !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        chk("b_tx_ready_wait", tx_ready_b, 1);
        tx_data_b  = d;
        tx_valid_b = 1'b1;
        @(negedge clk);
        tx_valid_b = 1'b0;
        frame_len = 0;
        got = 1'b0;
        for (int i = 0; i < 200 && !(got && tx_ready_b === 1'b1); i++) begin
            if (tx_ready_b === 1'b0) frame_len++;
            if (rx_valid_b === 1'b1 && !got) begin
                got = 1'b1;
                chk("b_rx_data", rx_data_b, d);
                chk("b_rx_perr", rx_perr_b, 0);
                chk("b_rx_ferr", rx_ferr_b, 0);
            end
            @(negedge clk);
        end
        chk("b_frame_received", got, 1);
        chk("b_frame_len_cycles", frame_len, (1 + 7 + 1 + 2) * BIT);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       par_flip;
        logic       stop_val;
        logic       exp_perr;
        logic       exp_ferr;
    } rx_vec_t;
    rx_vec_t vecs[5];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        logic [7:0] exp_q[$];
        logic [7:0] d;
        int ovr_base, lows, seen;

        vecs[0] = '{8'h55, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'h80, 1'b1, 1'b0, 1'b1, 1'b1};

        rst_n = 1'b0;
        tx_data_a = '0; tx_valid_a = 1'b0; cts_a = 1'b1; rxd_a = 1'b1; rx_ready_a = 1'b0;
        tx_data_b = '0; tx_valid_b = 1'b0; cts_b = 1'b1; rx_ready_b = 1'b1;
        tx_data_c = '0; tx_valid_c = 1'b0; cts_c = 1'b1; rxd_c = 1'b1; rx_ready_c = 1'b0;
        repeat (4) @(negedge clk);

        // Reset state
        chk("rst_txd_a", txd_a, 1);
        chk("rst_tx_ready_a", tx_ready_a, 0);
        chk("rst_rts_a", rts_a, 1);
        chk("rst_rx_valid_a", rx_valid_a, 0);
        chk("rst_rx_perr_a", rx_perr_a, 0);
        chk("rst_rx_ferr_a", rx_ferr_a, 0);
        chk("rst_rx_overrun_a", rx_overrun_a, 0);
        chk("rst_txd_b", txd_b, 1);
        chk("rst_tx_ready_b", tx_ready_b, 0);
        chk("rst_rts_bc", {rts_b, rts_c}, 2'b11);
        chk("rst_txd_c", txd_c, 1);
        chk("rst_tx_ready_c", tx_ready_c, 0);
        chk("rst_overrun_bc", {rx_overrun_b, rx_overrun_c}, 2'b00);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // cts through the synchronizer: tx_ready follows three edges later
        cts_a = 1'b0;
        repeat (6) @(negedge clk);
        chk("a_tx_ready_cts_low", tx_ready_a, 0);
        cts_a = 1'b1;
        @(negedge clk);
        chk("a_tx_ready_sync_1", tx_ready_a, 0);
        @(negedge clk);
        chk("a_tx_ready_sync_2", tx_ready_a, 0);
        @(negedge clk);
        chk("a_tx_ready_sync_3", tx_ready_a, 1);

        // TX waveform: 0xA5 then random bytes, one with cts dropped mid-frame
        tx_frame_a(8'hA5, 1'b0);
        for (int i = 0; i < 4; i++) tx_frame_a(8'($urandom_range(0, 255)), (i == 1));

        // 7E2 loopback
        loop_b(7'h41);
        for (int i = 0; i < 4; i++) loop_b(7'($urandom_range(0, 127)));

        // Odd-parity receive vectors
        foreach (vecs[i]) begin
            drive_rx(1, vecs[i].data, 1, vecs[i].par_flip, vecs[i].stop_val);
            chk("c_rx_valid", rx_valid_c, 1);
            chk("c_rx_data", rx_data_c, vecs[i].data);
            chk("c_rx_perr", rx_perr_c, vecs[i].exp_perr);
            chk("c_rx_ferr", rx_ferr_c, vecs[i].exp_ferr);
            rx_ready_c = 1'b1;
            @(negedge clk);
            rx_ready_c = 1'b0;
            chk("c_rx_empty_after_pop", rx_valid_c, 0);
        end

        // Fill the FIFO on port A: rts, overrun and ordering
        ovr_base = ovr_cnt;
        for (int f = 1; f <= 5; f++) begin
            d = 8'($urandom_range(0, 255));
            if (f <= 4) exp_q.push_back(d);
            drive_rx(0, d, 0, 1'b0, 1'b1);
            chk("a_rts_after_frame", rts_a, ((f < 4 ? f : 4) <= 2) ? 1 : 0);
            chk("a_overrun_pulses", ovr_cnt - ovr_base, (f == 5) ? 1 : 0);
        end
        for (int i = 0; i < 4; i++) begin
            chk("a_pop_valid", rx_valid_a, 1);
            chk("a_pop_data", rx_data_a, exp_q[i]);
            chk("a_pop_flags", {rx_perr_a, rx_ferr_a}, 2'b00);
            rx_ready_a = 1'b1;
            @(negedge clk);
            rx_ready_a = 1'b0;
        end
        chk("a_empty_after_pops", rx_valid_a, 0);
        repeat (2) @(negedge clk);
        chk("a_rts_after_pops", rts_a, 1);

        // False start: three low cycles
        rxd_a = 1'b0;
        repeat (3) @(negedge clk);
        rxd_a = 1'b1;
        repeat (12 * BIT) @(negedge clk);
        chk("a_false_start_no_push", rx_valid_a, 0);

        // Reset in the middle of a TX frame and an RX frame
        tx_data_a  = 8'h0F;
        tx_valid_a = 1'b1;
        rxd_a      = 1'b0;
        @(negedge clk);
        tx_valid_a = 1'b0;
        repeat (3 * BIT) @(negedge clk);
        rxd_a = 1'b1;
        repeat (BIT) @(negedge clk);
        rxd_a = 1'b0;
        repeat (BIT) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("a_txd_high_in_reset", txd_a, 1);
        chk("a_tx_ready_low_in_reset", tx_ready_a, 0);
        @(negedge clk);
        rxd_a = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        lows = 0;
        seen = 0;
        for (int i = 0; i < 15 * BIT; i++) begin
            @(negedge clk);
            if (txd_a !== 1'b1) lows++;
            if (rx_valid_a !== 1'b0) seen++;
        end
        chk("a_txd_idle_after_reset", lows, 0);
        chk("a_fifo_empty_after_reset", seen, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_port.md
UART_PORT -- requirements
Module: uart_port

Interface
REQ-001 Parameter BIT_CLK, default 87: clk cycles per serial bit; legal values are 4 or more.
REQ-002 Parameter DATA_BITS, default 8: payload width; legal values are 5 to 8.
REQ-003 Parameter PARITY, default 0: 0 = none, 1 = odd, 2 = even.
REQ-004 Parameter STOP_BITS, default 1: legal values are 1 or 2.
REQ-005 Parameter RX_DEPTH, default 4: RX FIFO entries; power of two, at least 2.
REQ-006 Port clk, in, 1: the only clock; all logic SHALL be on its rising edge.
REQ-007 Port rst_n, in, 1: reset, asynchronous and active-low.
REQ-008 Port tx_data, in, DATA_BITS: byte to transmit.
REQ-009 Port tx_valid, in, 1: tx_data is valid.
REQ-010 Port tx_ready, out, 1: transmitter accepts a byte this cycle.
REQ-011 Port txd, out, 1: serial output; idles high.
REQ-012 Port cts, in, 1: high means the peer may receive (asynchronous input).
REQ-013 Port rxd, in, 1: serial input (asynchronous input).
REQ-014 Port rts, out, 1: high means the local RX FIFO can take more frames.
REQ-015 Port rx_data, out, DATA_BITS: head entry of the RX FIFO.
REQ-016 Port rx_valid, out, 1: the FIFO is non-empty.
REQ-017 Port rx_ready, in, 1: consumer pops the head entry.
REQ-018 Port rx_perr, out, 1: head entry had a parity error.
REQ-019 Port rx_ferr, out, 1: head entry had a bad stop bit.
REQ-020 Port rx_overrun, out, 1: one-cycle pulse when a complete frame is dropped because the FIFO is full.

Function
REQ-021 cts and rxd SHALL each pass through a 2-flop synchronizer before use.
REQ-022 TX FSM states: IDLE, START, DATA, PARITY, STOP; each state holds its bit for BIT_CLK cycles.
REQ-023 TX sequencing:
- tx_ready = 1 only in IDLE and only while synchronized cts = 1.
- A byte is accepted when tx_valid && tx_ready; it is latched and txd goes low on the next cycle.
REQ-024 Data SHALL be sent LSB first.
REQ-025 PARITY state is skipped when PARITY = 0; the parity bit makes the count of ones odd (PARITY = 1) or even (PARITY = 2).
REQ-026 STOP lasts STOP_BITS*BIT_CLK cycles with txd high, then returns to IDLE.
- Back-to-back frames SHALL have no extra idle gap.
REQ-027 cts deasserting mid-frame SHALL NOT abort the frame; cts is evaluated only at acceptance.
REQ-028 RX FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE to START on a synchronized falling edge.
- At BIT_CLK/2 (integer division) START re-checks the line: if it is high, this is a false start; return to IDLE with no push.
- After the start check, every later bit is sampled at BIT_CLK-cycle intervals, i.e. at its centre.
REQ-029 RX checks only the first stop bit; the RX FSM SHALL return to IDLE immediately after sampling it.
REQ-030 At the end of the stop bit, the frame is pushed as {data, perr, ferr}.
- ferr = 1 when the stop sample is low.
- perr = 1 on a parity mismatch; perr is always 0 when PARITY = 0.
- Frames with errors SHALL still be pushed.
REQ-031 RX FIFO behaviour:
- First-word-fall-through.
- Pop on rx_valid && rx_ready.
- A push and a pop in the same cycle SHALL both succeed, including when the FIFO is full.
- When the FIFO is full and no pop occurs in that cycle, the frame is dropped and rx_overrun pulses for one cycle.
REQ-032 rts = 1 while the occupancy is at most RX_DEPTH-2 (at least two free entries); this is registered.
REQ-033 rx_data, rx_perr and rx_ferr are don't-care while rx_valid = 0.

Reset
REQ-034 While rst_n is low:
- Both FSMs are in IDLE and all counters are zero.
- The FIFO is empty.
- txd = 1, tx_ready = 0, rts = 1, rx_valid = 0, rx_perr = 0, rx_ferr = 0, rx_overrun = 0.
- Both synchronizers reset high.
REQ-035 Reset mid-frame SHALL abort both directions immediately; no partial frame is pushed after release.
REQ-036 tx_ready SHALL NOT assert until the cycle after cts is seen high through the synchronizer.

Structure
REQ-037 Shared package uart_pkg SHALL hold:
- the parity-mode constants (NONE, ODD, EVEN);
- the TX and RX state enums;
- a helper function for the parity bit.
REQ-038 The block SHALL have one sub-module, uart_rx_fifo, parametrised by width (DATA_BITS+2) and RX_DEPTH.
- The TX and RX FSMs stay inline in uart_port.

Verification
REQ-039 Setup BIT_CLK=8, 8N1, cts=1. Send 0xA5 → txd shows 0, 1,0,1,0,0,1,0,1, 1, each bit 8 cycles wide; tx_ready low for 80 cycles.
REQ-040 Setup 7E2, txd looped to rxd. Send 0x41 → rx_data=0x41, rx_perr=0, rx_ferr=0; frame length 11 bits.
REQ-041 Setup odd parity. Drive rxd with 0x55 and a wrong parity bit, then a second frame with a low stop bit → first entry perr=1; second entry ferr=1, data intact.
REQ-042 Setup RX_DEPTH=4, rx_ready=0. Receive 5 frames → rts falls after frame 3; frame 5 dropped with one rx_overrun pulse; pops return frames 1-4 in order.
REQ-043 Drive rxd low for 3 cycles at BIT_CLK=8 → no push. Then assert rst_n low mid-frame → txd=1 at once; FIFO empty after release.
